// File: rtl/inv_chk_pkg.sv
// Shared definitions for the inverter result checker: FSM state encoding and
// default data/counter widths.
package inv_chk_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        HALT  = 3'd3,
        DONE  = 3'd4
    } inv_chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count one step; holds at all-ones
//   count      : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/inv_result_checker.sv
// Checks that each inverter output equals the bitwise complement of its
// stimulus, counting checked and mismatching pairs and capturing the stimulus
// of the first mismatch in a check window.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, stop     : open / close a check window
//   in_valid/ready  : pair handshake (ready only in RUN)
//   in_word         : stimulus applied to the inverter
//   out_word        : inverter output for in_word
//   busy, done      : window running / window finished
//   err_flag        : sticky mismatch flag for the current window
//   word_count      : pairs checked (saturating)
//   err_count       : mismatching pairs (saturating)
//   first_err_word  : in_word of the first mismatch
module inv_result_checker
    import inv_chk_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic [WIDTH-1:0] out_word,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] first_err_word
);

    inv_chk_state_e state_q;
    inv_chk_state_e state_nxt;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_in;
    logic [WIDTH-1:0] s1_out;

    logic accept_c;
    logic restart_c;
    logic mismatch_c;

    // A pair offered together with stop is refused so the window closes cleanly.
    assign accept_c   = in_valid && (state_q == RUN) && !stop;
    assign mismatch_c = s1_valid && (s1_out != ~s1_in);

    // Next-state logic; a halting mismatch takes priority over stop.
    always_comb begin
        state_nxt = state_q;
        restart_c = 1'b0;
        case (state_q)
            IDLE, DONE, HALT: begin
                if (start) begin
                    state_nxt = RUN;
                    restart_c = 1'b1;
                end
            end
            RUN: begin
                if (HALT_ON_ERR && mismatch_c) begin
                    state_nxt = HALT;
                end else if (stop) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (HALT_ON_ERR && mismatch_c) begin
                    state_nxt = HALT;
                end else if (!s1_valid) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            in_ready <= (state_nxt == RUN);
            busy     <= (state_nxt == RUN);
            done     <= (state_nxt == DONE);
        end
    end

    // Stage 1: capture the accepted pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_in    <= '0;
            s1_out   <= '0;
        end else begin
            s1_valid <= accept_c && !restart_c;
            if (accept_c) begin
                s1_in  <= in_word;
                s1_out <= out_word;
            end
        end
    end

    // Stage 2: sticky error flag and first failing stimulus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag       <= 1'b0;
            first_err_word <= '0;
        end else if (restart_c) begin
            err_flag       <= 1'b0;
            first_err_word <= '0;
        end else if (mismatch_c) begin
            err_flag <= 1'b1;
            if (!err_flag) begin
                first_err_word <= s1_in;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart_c),
        .en    (s1_valid),
        .count (word_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (restart_c),
        .en    (mismatch_c),
        .count (err_count)
    );

endmodule

// File: tb/tb_inv_result_checker.sv
// Bench for inv_result_checker: three instances (halting, non-halting,
// 2-bit counters) share one stimulus stream.
module tb_inv_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        in_valid;
    logic [31:0] in_word;
    logic [31:0] out_word;

    logic        h_in_ready, h_busy, h_done, h_err_flag;
    logic [15:0] h_word_count, h_err_count;
    logic [31:0] h_first;
    logic        c_in_ready, c_busy, c_done, c_err_flag;
    logic [15:0] c_word_count, c_err_count;
    logic [31:0] c_first;
    logic        s_in_ready, s_busy, s_done, s_err_flag;
    logic [1:0]  s_word_count, s_err_count;
    logic [31:0] s_first;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_result_checker #(.WIDTH(32), .CNT_W(16), .HALT_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_word(in_word), .out_word(out_word),
        .busy(h_busy), .done(h_done), .err_flag(h_err_flag),
        .word_count(h_word_count), .err_count(h_err_count), .first_err_word(h_first)
    );

    inv_result_checker #(.WIDTH(32), .CNT_W(16), .HALT_ON_ERR(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_word(in_word), .out_word(out_word),
        .busy(c_busy), .done(c_done), .err_flag(c_err_flag),
        .word_count(c_word_count), .err_count(c_err_count), .first_err_word(c_first)
    );

    inv_result_checker #(.WIDTH(32), .CNT_W(2), .HALT_ON_ERR(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_word(in_word), .out_word(out_word),
        .busy(s_busy), .done(s_done), .err_flag(s_err_flag),
        .word_count(s_word_count), .err_count(s_err_count), .first_err_word(s_first)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] o);
        in_valid = 1'b1;
        in_word  = w;
        out_word = o;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        in_valid = 1'b0;
        stop     = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Random-window model state: "all" = non-halting view, "h" = halting view.
    int          n_all, e_all, n_h, e_h, halt_cyc, cyc, npairs;
    logic [31:0] first_all, first_h, w, o;
    bit          bad;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        in_valid = 1'b0; in_word = '0; out_word = '0;
        tick(); tick();

        // Reset state
        check("rst_in_ready", 32'(h_in_ready), 32'd0);
        check("rst_busy", 32'(h_busy), 32'd0);
        check("rst_done", 32'(c_done), 32'd0);
        check("rst_err_flag", 32'(h_err_flag), 32'd0);
        check("rst_word_count", 32'(c_word_count), 32'd0);
        check("rst_first", h_first, 32'd0);
        rst_n = 1'b1;
        tick();

        // Good pairs, back to back
        do_start();
        check("start_busy", 32'(h_busy), 32'd1);
        check("start_in_ready", 32'(c_in_ready), 32'd1);
        send(32'h0000_0000, 32'hFFFF_FFFF);
        send(32'h0000_0001, 32'hFFFF_FFFE);
        send(32'hFFFF_FFFF, 32'h0000_0000);
        do_stop();
        check("good_word_count", 32'(c_word_count), 32'd3);
        check("good_err_count", 32'(c_err_count), 32'd0);
        check("good_err_flag", 32'(h_err_flag), 32'd0);
        check("good_done", 32'(h_done), 32'd1);
        check("good_busy", 32'(h_busy), 32'd0);

        // Halt on first mismatch; the following pair is still counted
        do_start();
        send(32'd5, 32'hFFFF_FFF0);
        send(32'd0, 32'hFFFF_FFFF);
        check("halt_flag_edge", 32'(h_err_flag), 32'd1);
        check("halt_ready_edge", 32'(h_in_ready), 32'd0);
        check("halt_wc_edge", 32'(h_word_count), 32'd1);
        in_valid = 1'b0;
        tick();
        check("halt_word_count", 32'(h_word_count), 32'd2);
        check("halt_err_count", 32'(h_err_count), 32'd1);
        check("halt_first", h_first, 32'd5);
        tick();
        check("halt_in_ready", 32'(h_in_ready), 32'd0);
        check("halt_busy", 32'(h_busy), 32'd0);
        check("halt_done", 32'(h_done), 32'd0);
        check("halt_err_flag", 32'(h_err_flag), 32'd1);
        check("nohalt_ready", 32'(c_in_ready), 32'd1);
        do_stop();
        check("halt_ignores_stop", 32'(h_done), 32'd0);
        check("halt_wc_hold", 32'(h_word_count), 32'd2);

        // Continue on error
        do_start();
        send(32'd3, 32'h0000_0000);
        send(32'd4, 32'hFFFF_FFFB);
        send(32'd7, 32'h0000_0007);
        send(32'd8, 32'hFFFF_FFF7);
        do_stop();
        check("cont_err_count", 32'(c_err_count), 32'd2);
        check("cont_first", c_first, 32'd3);
        check("cont_word_count", 32'(c_word_count), 32'd4);
        check("cont_done", 32'(c_done), 32'd1);
        check("cont_s_word_count", 32'(s_word_count), 32'd3);
        check("cont_s_err_count", 32'(s_err_count), 32'd2);
        check("cont_h_word_count", 32'(h_word_count), 32'd2);
        check("cont_h_first", h_first, 32'd3);

        // Saturation
        do_start();
        for (int i = 0; i < 5; i++) send(32'(i + 10), ~32'(i + 10));
        do_stop();
        check("sat_s_word_count", 32'(s_word_count), 32'd3);
        check("sat_c_word_count", 32'(c_word_count), 32'd5);
        check("sat_s_done", 32'(s_done), 32'd1);

        // stop together with in_valid
        do_start();
        send(32'd20, ~32'd20);
        in_valid = 1'b1; in_word = 32'd21; out_word = ~32'd21; stop = 1'b1;
        tick();
        in_valid = 1'b0; stop = 1'b0;
        check("stopv_in_ready", 32'(c_in_ready), 32'd0);
        check("stopv_done_early", 32'(c_done), 32'd0);
        tick();
        check("stopv_done", 32'(c_done), 32'd1);
        check("stopv_word_count", 32'(c_word_count), 32'd1);
        // start + stop in DONE: start wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_done_busy", 32'(c_busy), 32'd1);
        check("ss_done_wc", 32'(c_word_count), 32'd0);
        check("ss_done_ready", 32'(c_in_ready), 32'd1);
        // start + stop in RUN: stop wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_run_busy", 32'(c_busy), 32'd0);
        tick();
        check("ss_run_done", 32'(c_done), 32'd1);

        // Reset with a pair in stage 1
        do_start();
        send(32'd9, 32'd9);
        send(32'd10, ~32'd10);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_wc", 32'(c_word_count), 32'd0);
        check("mrst_ec", 32'(c_err_count), 32'd0);
        check("mrst_flag", 32'(h_err_flag), 32'd0);
        check("mrst_first", c_first, 32'd0);
        check("mrst_busy", 32'(c_busy), 32'd0);
        check("mrst_ready", 32'(c_in_ready), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_wc", 32'(c_word_count), 32'd0);
        check("post_rst_h_wc", 32'(h_word_count), 32'd0);
        check("post_rst_busy", 32'(c_busy), 32'd0);
        check("post_rst_done", 32'(c_done), 32'd0);

        // Randomized windows against a transaction-level model
        for (int r = 0; r < 8; r++) begin
            n_all = 0; e_all = 0; n_h = 0; e_h = 0;
            halt_cyc = -1; cyc = 0;
            first_all = '0; first_h = '0;
            npairs = int'($urandom_range(1, 12));
            do_start();
            for (int i = 0; i < npairs; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    tick();
                    cyc++;
                end
                w   = $urandom;
                bad = ($urandom_range(0, 3) == 0);
                o   = bad ? (~w ^ (32'h1 << $urandom_range(0, 31))) : ~w;
                if (bad && e_all == 0) first_all = w;
                n_all++;
                if (bad) e_all++;
                // Halting instance takes pairs up to one cycle after the first bad one.
                if (halt_cyc < 0 || cyc <= halt_cyc + 1) begin
                    n_h++;
                    if (bad) begin
                        e_h++;
                        if (halt_cyc < 0) begin
                            halt_cyc = cyc;
                            first_h  = w;
                        end
                    end
                end
                send(w, o);
                cyc++;
            end
            do_stop();
            check($sformatf("rnd%0d_c_wc", r), 32'(c_word_count), 32'(sat(n_all, 65535)));
            check($sformatf("rnd%0d_c_ec", r), 32'(c_err_count), 32'(sat(e_all, 65535)));
            check($sformatf("rnd%0d_c_first", r), c_first, first_all);
            check($sformatf("rnd%0d_c_flag", r), 32'(c_err_flag), 32'(e_all != 0));
            check($sformatf("rnd%0d_c_done", r), 32'(c_done), 32'd1);
            check($sformatf("rnd%0d_s_wc", r), 32'(s_word_count), 32'(sat(n_all, 3)));
            check($sformatf("rnd%0d_s_ec", r), 32'(s_err_count), 32'(sat(e_all, 3)));
            check($sformatf("rnd%0d_h_wc", r), 32'(h_word_count), 32'(n_h));
            check($sformatf("rnd%0d_h_ec", r), 32'(h_err_count), 32'(e_h));
            check($sformatf("rnd%0d_h_first", r), h_first, first_h);
            check($sformatf("rnd%0d_h_flag", r), 32'(h_err_flag), 32'(e_h != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
